// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter driving a single memory bus through a fixed
// four-state transaction (IDLE, START, XFER, DONE). Illegal opcodes run without a grant.
module mem_bus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        mode0,
  input  logic [1:0]        mode1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              rdy0,
  output logic              rdy1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_start,
  output logic              bus_gnt,
  output logic [1:0]        bus_mode,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wen,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [15:0]       xfer_cnt
);

  typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;
  logic                last_q, last_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [15:0]         xfer_cnt_q, xfer_cnt_d;
  logic                legal;
  logic                active;

  assign legal  = ~mode_q[1];
  assign active = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      last_q     <= 1'b1;
      mode_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    xfer_cnt_d = xfer_cnt_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = START;
          // On a tie the requester not granted last wins; a sole requester always wins.
          win_d   = (req0 && req1) ? ~last_q : req1;
          mode_d  = win_d ? mode1  : mode0;
          addr_d  = win_d ? addr1  : addr0;
          wdata_d = win_d ? wdata1 : wdata0;
        end
      end
      START: state_d = XFER;
      XFER: begin
        state_d = DONE;
        if (mode_q == 2'd0) rdata_d = bus_rdata;
      end
      DONE: begin
        state_d = IDLE;
        last_d  = win_q;
        if (legal) xfer_cnt_d = xfer_cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_start = (state_q == START);
  assign bus_gnt   = (state_q == XFER) && legal;
  assign bus_wen   = (state_q == XFER) && (mode_q == 2'd1);
  assign bus_wdata = bus_wen ? wdata_q : '0;
  assign bus_mode  = active ? mode_q : 2'd0;
  assign bus_addr  = active ? addr_q : '0;
  assign rdy0      = (state_q == DONE) && !win_q;
  assign rdy1      = (state_q == DONE) &&  win_q;
  assign err0      = rdy0 && !legal;
  assign err1      = rdy1 && !legal;
  assign rdata     = rdata_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule
